// File: rtl/parity_pkg.sv
// parity_pkg: shared states and constants for the parity frame receiver and generator.
package parity_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD = 1;
    localparam int ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(255);
endpackage

// File: rtl/parity_calc.sv
// parity_calc: XOR reduction shared by both ends of the link so parity logic stays identical.
module parity_calc #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] data,
    output logic              par
);
    assign par = ^data;
endmodule

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: deframes start/data/parity/stop from sdi, checks parity and framing,
// and keeps a saturating count of errored frames.
module parity_frame_rx
    import parity_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ODD_PARITY = PARITY_EVEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              sdi,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic [ERR_W-1:0]  err_cnt
);
    localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;

    state_t            state, next;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] sh;
    logic              run_par, mis, calc_par, last;

    assign last = idx == IW'(DATA_W - 1);
    assign busy = state != IDLE;

    always_comb begin
        next = state;
        if (bit_en)
            case (state)
                IDLE:    next = sdi ? IDLE : DATA;
                DATA:    next = last ? PARITY : DATA;
                PARITY:  next = STOP;
                default: next = IDLE;
            endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= next;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            idx        <= '0;
            sh         <= '0;
            run_par    <= 1'b0;
            mis        <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            err_cnt    <= '0;
        end else begin
            valid <= 1'b0;
            if (bit_en)
                case (state)
                    IDLE: begin
                        idx     <= '0;
                        run_par <= 1'b0;
                    end
                    DATA: begin
                        sh[idx] <= sdi;
                        run_par <= run_par ^ sdi;
                        if (!last) idx <= idx + 1'b1;
                    end
                    PARITY: mis <= run_par ^ sdi ^ 1'(ODD_PARITY);
                    default: begin
                        valid      <= 1'b1;
                        data_out   <= sh;
                        parity_err <= mis;
                        frame_err  <= !sdi;
                        if ((mis || !sdi) && err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
                    end
                endcase
        end

    // The running parity must agree with a full reduction of the assembled word.
    parity_calc #(.DATA_W(DATA_W)) u_calc (.data(sh), .par(calc_par));

    always_ff @(posedge clk)
        if (!rst && state == STOP) assert (calc_par == run_par);
endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: directed frames into even and odd receivers, scoreboard-checked on valid.
module tb_parity_frame_rx;
    logic       clk = 0, rst = 1, bit_en = 0, sdi_e = 1, sdi_o = 1;
    logic [3:0] data_e, data_o;
    logic       valid_e, valid_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;
    logic [7:0] cnt_e, cnt_o;

    typedef struct {logic [3:0] d; logic pe; logic fe; logic [7:0] cnt;} exp_t;
    exp_t q_e[$], q_o[$];
    int n_chk = 0, n_fail = 0, mc_e = 0, mc_o = 0;
    logic pv_e = 0, pv_o = 0;

    always #5 clk = ~clk;

    parity_frame_rx #(.DATA_W(4), .ODD_PARITY(0)) dut_e (
        .clk(clk), .rst(rst), .bit_en(bit_en), .sdi(sdi_e), .data_out(data_e), .valid(valid_e),
        .parity_err(pe_e), .frame_err(fe_e), .busy(busy_e), .err_cnt(cnt_e));

    parity_frame_rx #(.DATA_W(4), .ODD_PARITY(1)) dut_o (
        .clk(clk), .rst(rst), .bit_en(bit_en), .sdi(sdi_o), .data_out(data_o), .valid(valid_o),
        .parity_err(pe_o), .frame_err(fe_o), .busy(busy_o), .err_cnt(cnt_o));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        if (valid_e) begin
            exp_t x;
            chk("pulse_width_e", pv_e, 0);
            if (q_e.size() == 0) chk("unexpected_valid_e", 1, 0);
            else begin
                x = q_e.pop_front();
                chk("data_e", data_e, x.d);
                chk("parity_err_e", pe_e, x.pe);
                chk("frame_err_e", fe_e, x.fe);
                chk("err_cnt_e", cnt_e, x.cnt);
            end
        end
        pv_e = valid_e;
    end

    always @(negedge clk) if (!rst) begin
        if (valid_o) begin
            exp_t x;
            chk("pulse_width_o", pv_o, 0);
            if (q_o.size() == 0) chk("unexpected_valid_o", 1, 0);
            else begin
                x = q_o.pop_front();
                chk("data_o", data_o, x.d);
                chk("parity_err_o", pe_o, x.pe);
                chk("frame_err_o", fe_o, x.fe);
                chk("err_cnt_o", cnt_o, x.cnt);
            end
        end
        pv_o = valid_o;
    end

    task automatic bit_out(input bit o, input logic b, input int gap);
        if (o) sdi_o = b; else sdi_e = b;
        bit_en = 1;
        @(posedge clk); #1;
        for (int i = 0; i < gap; i++) begin
            bit_en = 0;
            if (o) sdi_o = ~b; else sdi_e = ~b;
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input bit o, input logic [3:0] d, input logic p, input logic s,
                        input logic pe, input logic fe, input int gap);
        exp_t x;
        int c;
        c = o ? mc_o : mc_e;
        if ((pe || fe) && c < 255) c++;
        if (o) mc_o = c; else mc_e = c;
        x = '{d, pe, fe, 8'(c)};
        if (o) q_o.push_back(x); else q_e.push_back(x);
        bit_out(o, 0, gap);
        chk("busy_after_start", o ? busy_o : busy_e, 1);
        for (int i = 0; i < 4; i++) bit_out(o, d[i], gap);
        bit_out(o, p, gap);
        if (o) sdi_o = s; else sdi_e = s;
        bit_en = 1;
        @(posedge clk); #1;
        chk("valid_latency", o ? valid_o : valid_e, 1);
        chk("busy_after_stop", o ? busy_o : busy_e, 0);
        if (o) sdi_o = 1; else sdi_e = 1;
    endtask

    initial begin
        #3;
        chk("reset_e", {data_e, valid_e, pe_e, fe_e, busy_e, cnt_e}, 0);
        chk("reset_o", {data_o, valid_o, pe_o, fe_o, busy_o, cnt_o}, 0);
        @(posedge clk); #1 rst = 0;
        bit_en = 1;
        repeat (20) begin
            @(posedge clk); #1;
            chk("idle_busy", busy_e, 0);
        end
        chk("idle_outputs", {data_e, valid_e, pe_e, fe_e, cnt_e}, 0);
        send(0, 4'b1011, 1, 1, 0, 0, 0);
        send(0, 4'b1011, 0, 1, 1, 0, 0);
        send(0, 4'b0000, 0, 0, 0, 1, 0);
        send(0, 4'b0110, 0, 1, 0, 0, 0);
        bit_out(0, 0, 0);
        bit_out(0, 1, 0);
        bit_out(0, 1, 0);
        rst = 1;
        #1;
        chk("async_reset", {data_e, pe_e, fe_e, busy_e, cnt_e}, 0);
        mc_e = 0;
        sdi_e = 1;
        @(posedge clk); #1 rst = 0;
        send(0, 4'b1111, 0, 1, 0, 0, 2);
        send(0, 4'b0001, 0, 0, 1, 1, 0);
        repeat (300) send(1, 4'b1011, 1, 1, 1, 0, 0);
        send(1, 4'b1011, 0, 1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty_e", q_e.size(), 0);
        chk("queue_empty_o", q_o.size(), 0);
        chk("cnt_hold_o", cnt_o, 255);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
